// File: rtl/gray_run_ctrl_if.sv
// gray_run_ctrl_if -- request/status bundle for gray_run_ctrl.
//   Requester -> controller : start, start_val, steps, hold, abort
//   Controller -> requester : busy, done, wrap, bin, gray
//   master modport : host/sequencer side
//   slave  modport : controller side
interface gray_run_ctrl_if #(
   parameter int SIZE = 3
);
   logic            start;
   logic [SIZE-1:0] start_val;
   logic [SIZE-1:0] steps;
   logic            hold;
   logic            abort;
   logic            busy;
   logic            done;
   logic            wrap;
   logic [SIZE-1:0] bin;
   logic [SIZE-1:0] gray;

   modport master (
      output start, start_val, steps, hold, abort,
      input  busy, done, wrap, bin, gray
   );

   modport slave (
      input  start, start_val, steps, hold, abort,
      output busy, done, wrap, bin, gray
   );
endinterface

// File: rtl/gray_run_ctrl.sv
// gray_run_ctrl -- runs a SIZE-bit binary counter with Gray-coded output
// through a programmed number of increments, with pause and abort.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : slave side of gray_run_ctrl_if
//           start/start_val/steps : run request, sampled only in IDLE
//           hold/abort            : pause / terminate (abort wins over hold)
//           busy/done/wrap        : run in progress / completion pulse /
//                                   all-ones -> 0 pulse
//           bin/gray              : registered count and its Gray code
module gray_run_ctrl #(
   parameter int SIZE = 3
) (
   input  logic            clk,
   input  logic            reset,
   gray_run_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [SIZE-1:0] bin_q, bin_d;
   logic [SIZE-1:0] rem_q, rem_d;
   logic            wrap_q, wrap_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         bin_q   <= '0;
         rem_q   <= '0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         rem_q   <= rem_d;
         wrap_q  <= wrap_d;
      end
   end

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      rem_d   = rem_q;
      // wrap is a pulse: any edge that does not wrap clears it
      wrap_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               bin_d   = bus.start_val;
               rem_d   = bus.steps;
               // a zero-step run skips counting and only pulses done
               state_d = (bus.steps != '0) ? RUN : DONE;
            end
         end

         RUN: begin
            if (bus.abort) begin
               state_d = IDLE;
            end else if (bus.hold) begin
               state_d = HOLD;
            end else begin
               bin_d  = bin_q + SIZE'(1);
               rem_d  = rem_q - SIZE'(1);
               wrap_d = &bin_q;
               // leaving at rem==1 keeps rem from ever underflowing
               if (rem_q == SIZE'(1)) begin
                  state_d = DONE;
               end
            end
         end

         HOLD: begin
            if (bus.abort) begin
               state_d = IDLE;
            end else if (!bus.hold) begin
               // resume edge does not count; next edge increments
               state_d = RUN;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.busy = (state_q != IDLE);
   assign bus.done = (state_q == DONE);
   assign bus.wrap = wrap_q;
   assign bus.bin  = bin_q;
   assign bus.gray = bin_q ^ (bin_q >> 1);
endmodule

// File: tb/tb_gray_run_ctrl.sv
// tb_gray_run_ctrl -- self-checking bench for gray_run_ctrl (SIZE=3).
// The expected trace of each run is derived from the run's parameters:
// bin = start + increments-so-far, with a hold of H edges costing H+1
// non-counting edges, followed by one DONE cycle and then IDLE.
module tb_gray_run_ctrl;
   localparam int SIZE = 3;
   localparam int M    = 1 << SIZE;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   logic [SIZE-1:0] gray_tab [M];

   gray_run_ctrl_if #(.SIZE(SIZE)) bus ();

   gray_run_ctrl #(.SIZE(SIZE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input int eb, input bit ebusy,
                            input bit edone, input bit ewrap);
      chk({tag, "_bin"},  32'(bus.bin),  32'(eb));
      chk({tag, "_gray"}, 32'(bus.gray), 32'(gray_tab[eb]));
      chk({tag, "_busy"}, 32'(bus.busy), 32'(ebusy));
      chk({tag, "_done"}, 32'(bus.done), 32'(edone));
      chk({tag, "_wrap"}, 32'(bus.wrap), 32'(ewrap));
      $display("t=%0t %s bin=%0d gray=%b busy=%b done=%b wrap=%b", $time, tag,
               bus.bin, bus.gray, bus.busy, bus.done, bus.wrap);
   endtask

   // One complete run. hold_j/abort_j are increment counts at which the
   // hold/abort is applied (-1 = never). noise pulses start while busy.
   task automatic do_run(input int s, input int n, input int hold_j, input int hold_len,
                         input int abort_j, input bit noise);
      int k;
      int stall;
      bit held;
      bit inc_last;
      int b;
      bit aborted;
      k = 0; stall = 0; held = 0; inc_last = 0; aborted = 0;
      @(negedge clk);
      bus.start = 1'b1; bus.start_val = SIZE'(s); bus.steps = SIZE'(n);
      bus.hold = 1'b0; bus.abort = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      b = s % M;
      if (n != 0) begin
         for (int cyc = 0; cyc < 64; cyc++) begin
            b = (s + k) % M;
            check_out("run", b, 1'b1, 1'b0, inc_last && (b == 0));
            bus.abort = 1'b0;
            bus.start = noise ? 1'($urandom % 2) : 1'b0;
            bus.start_val = SIZE'($urandom);
            bus.steps = SIZE'($urandom);
            if (stall == 0 && !held && hold_len > 0 && k == hold_j) begin
               stall = hold_len + 1;
               held = 1'b1;
            end
            bus.hold = (stall > 1);
            if (k == abort_j) begin
               bus.abort = 1'b1;
               aborted = 1'b1;
               break;
            end
            @(negedge clk);
            if (stall > 0) begin
               stall--;
               inc_last = 1'b0;
            end else begin
               k++;
               inc_last = 1'b1;
            end
            if (k == n) break;
         end
      end
      if (aborted) begin
         @(negedge clk);
         bus.abort = 1'b0; bus.hold = 1'b0; bus.start = 1'b0;
         check_out("abort_idle", b, 1'b0, 1'b0, 1'b0);
      end else begin
         b = (s + n) % M;
         check_out("done", b, 1'b1, 1'b1, inc_last && (b == 0));
         bus.start = noise; bus.hold = 1'b0; bus.abort = 1'b0;
         @(negedge clk);
         bus.start = 1'b0;
         check_out("idle", b, 1'b0, 1'b0, 1'b0);
      end
      // hold/abort are ignored in IDLE
      bus.hold = 1'($urandom % 2);
      bus.abort = 1'($urandom % 2);
      @(negedge clk);
      bus.hold = 1'b0; bus.abort = 1'b0;
      check_out("idle2", b, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      gray_tab[0] = 3'b000; gray_tab[1] = 3'b001; gray_tab[2] = 3'b011; gray_tab[3] = 3'b010;
      gray_tab[4] = 3'b110; gray_tab[5] = 3'b111; gray_tab[6] = 3'b101; gray_tab[7] = 3'b100;
      bus.start = 1'b0; bus.start_val = '0; bus.steps = '0;
      bus.hold = 1'b0; bus.abort = 1'b0;
      reset = 1'b1;
      #1 reset = 1'b0;
      #2 check_out("reset", 0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_out("post_reset", 0, 1'b0, 1'b0, 1'b0);

      // directed runs
      do_run(0, 7, -1, 0, -1, 1'b0);   // full count 0..7, no wrap
      do_run(6, 3, -1, 0, -1, 1'b0);   // 6,7,0,1 with wrap at 0
      do_run(0, 4, 2, 3, -1, 1'b0);    // hold 3 cycles at bin 2
      do_run(5, 0, -1, 0, -1, 1'b1);   // zero steps: immediate done
      do_run(0, 7, -1, 0, 3, 1'b1);    // abort at bin 3, starts ignored
      do_run(7, 1, -1, 0, -1, 1'b0);   // single step that wraps
      do_run(1, 5, 0, 1, 0, 1'b0);     // abort beats hold on same edge

      // asynchronous reset mid-run at bin 5
      @(negedge clk);
      bus.start = 1'b1; bus.start_val = 3'd3; bus.steps = 3'd7;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_out("pre_rst", 5, 1'b1, 1'b0, 1'b0);
      #2 reset = 1'b0;
      #1 check_out("async_rst", 0, 1'b0, 1'b0, 1'b0);
      #1 reset = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_out("rst_idle", 0, 1'b0, 1'b0, 1'b0);
      end

      // randomized runs
      for (int r = 0; r < 25; r++) begin
         int s, n, hj, hl, aj;
         s  = int'($urandom_range(0, M - 1));
         n  = int'($urandom_range(0, M - 1));
         hj = (n > 0) ? int'($urandom_range(0, n - 1)) : -1;
         hl = int'($urandom_range(0, 3));
         aj = (n > 0 && ($urandom % 3 == 0)) ? int'($urandom_range(0, n - 1)) : -1;
         do_run(s, n, hj, hl, aj, 1'($urandom % 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
